// File: rtl/pll_err_pio_ctrl_if.sv
// Avalon-MM slave bus bundle for the PLL error/status PIO.
// The CPU side uses the master modport, the PIO uses the slave modport.
interface pll_err_pio_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pll_err_pio_ctrl.sv
// Avalon-MM PIO for status/error signalling between the NIOS CPU and the
// PLL-configuration logic: output register with atomic set/clear, synchronised
// input port, and optional rising-edge capture with a maskable interrupt.
// Optional feature macro: PLLCFG_PIO_EDGE_IRQ_EN (builds IRQMASK, EDGECAP and irq).
module pll_err_pio_ctrl #(
  parameter int              OUT_W       = 8,
  parameter int              IN_W        = 8,
  parameter logic [OUT_W-1:0] OUT_RST_VAL = '0,
  parameter int              SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  pll_err_pio_ctrl_if.slave      bus,
  input  logic [IN_W-1:0]        in_port,
  output logic [OUT_W-1:0]       out_port,
  output logic                   irq
);

  logic             wr;
  logic             rd;
  logic [OUT_W-1:0] out_reg;
  logic [IN_W-1:0]  sync_chain [SYNC_STAGES];
  logic [IN_W-1:0]  sync_q;
  logic [31:0]      rd_mux;

  assign wr       = bus.chipselect & ~bus.write_n;
  assign rd       = bus.chipselect & ~bus.read_n;
  assign sync_q   = sync_chain[SYNC_STAGES-1];
  assign out_port = out_reg;

  // Output register: plain load, atomic OR-set and AND-NOT-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg <= OUT_RST_VAL;
    end else if (wr) begin
      case (bus.address)
        3'd0:    out_reg <= bus.writedata[OUT_W-1:0];
        3'd4:    out_reg <= out_reg | bus.writedata[OUT_W-1:0];
        3'd5:    out_reg <= out_reg & ~bus.writedata[OUT_W-1:0];
        default: out_reg <= out_reg;
      endcase
    end
  end

  // Multi-stage synchroniser bringing the asynchronous status inputs into clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= '0;
    end else begin
      sync_chain[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
    end
  end

`ifdef PLLCFG_PIO_EDGE_IRQ_EN
  logic [IN_W-1:0] irqmask;
  logic [IN_W-1:0] edgecap;
  logic [IN_W-1:0] sync_q_d;
  logic [IN_W-1:0] rise;
  logic [IN_W-1:0] w1c;

  assign rise = sync_q & ~sync_q_d;
  assign w1c  = (wr && bus.address == 3'd3) ? bus.writedata[IN_W-1:0] : '0;

  // Edge capture with write-one-to-clear; a fresh edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q_d <= '0;
      edgecap  <= '0;
      irqmask  <= '0;
      irq      <= 1'b0;
    end else begin
      sync_q_d <= sync_q;
      edgecap  <= rise | (edgecap & ~w1c);
      irq      <= |(edgecap & irqmask);
      if (wr && bus.address == 3'd2) irqmask <= bus.writedata[IN_W-1:0];
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read multiplexer over the current (pre-write) register contents.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0:    rd_mux = 32'(out_reg);
      3'd1:    rd_mux = 32'(sync_q);
`ifdef PLLCFG_PIO_EDGE_IRQ_EN
      3'd2:    rd_mux = 32'(irqmask);
      3'd3:    rd_mux = 32'(edgecap);
`endif
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
    end else if (rd) begin
      bus.readdata <= rd_mux;
    end else begin
      bus.readdata <= '0;
    end
  end

endmodule

// File: tb/tb_pll_err_pio_ctrl.sv
// Self-checking bench for pll_err_pio_ctrl: directed steps followed by
// randomized traffic, compared against a cycle-level reference model.
module tb_pll_err_pio_ctrl;
  localparam int              OUT_W = 8;
  localparam int              IN_W  = 8;
  localparam logic [OUT_W-1:0] RSTV  = 8'h00;
  localparam int              SYNC  = 2;

  logic             clk;
  logic             reset;
  logic [IN_W-1:0]  in_port;
  logic [OUT_W-1:0] out_port;
  logic             irq;

  pll_err_pio_ctrl_if bus ();

  pll_err_pio_ctrl #(
    .OUT_W(OUT_W), .IN_W(IN_W), .OUT_RST_VAL(RSTV), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [OUT_W-1:0] m_out;
  logic [IN_W-1:0]  m_mask;
  logic [IN_W-1:0]  m_cap;
  logic             m_irq;
  logic [31:0]      m_rd;
  logic [IN_W-1:0]  m_hist [SYNC];
  logic [IN_W-1:0]  m_prev;
  logic [IN_W-1:0]  cur_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed=0x%08h expected=0x%08h", tag, cycle, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [2:0] addr);
    case (addr)
      3'd0: return 32'(m_out);
      3'd1: return 32'(m_hist[SYNC-1]);
`ifdef PLLCFG_PIO_EDGE_IRQ_EN
      3'd2: return 32'(m_mask);
      3'd3: return 32'(m_cap);
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, clock, advance the model, then compare.
  task automatic applyStimulus(input logic rst, input logic cs, input logic [2:0] addr,
                               input logic do_wr, input logic do_rd,
                               input logic [31:0] wd, input logic [IN_W-1:0] inp);
    logic wr, rd;
    logic [IN_W-1:0] sq, rise, w1c;
    reset          = rst;
    bus.chipselect = cs;
    bus.address    = addr;
    bus.write_n    = ~do_wr;
    bus.read_n     = ~do_rd;
    bus.writedata  = wd;
    in_port        = inp;
    cur_in         = inp;
    wr = cs & do_wr;
    rd = cs & do_rd;
    @(posedge clk);
    cycle++;
    sq   = m_hist[SYNC-1];
    rise = sq & ~m_prev;
    if (rst) begin
      m_out = RSTV; m_mask = '0; m_cap = '0; m_irq = 1'b0; m_rd = '0; m_prev = '0;
      for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
    end else begin
      m_rd = rd ? modelRead(addr) : 32'd0;
`ifdef PLLCFG_PIO_EDGE_IRQ_EN
      w1c   = (wr && addr == 3'd3) ? wd[IN_W-1:0] : '0;
      m_irq = |(m_cap & m_mask);
      m_cap = rise | (m_cap & ~w1c);
      if (wr && addr == 3'd2) m_mask = wd[IN_W-1:0];
`else
      w1c = '0;
`endif
      if (wr) begin
        case (addr)
          3'd0: m_out = wd[OUT_W-1:0];
          3'd4: m_out = m_out | wd[OUT_W-1:0];
          3'd5: m_out = m_out & ~wd[OUT_W-1:0];
          default: ;
        endcase
      end
      m_prev = sq;
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = inp;
    end
    #1;
    checkOutput("out_port", 32'(out_port), 32'(m_out));
    checkOutput("irq", 32'(irq), 32'(m_irq));
    if (rst || rd) checkOutput("readdata", bus.readdata, m_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, cur_in);
  endtask

  initial begin
    m_out = RSTV; m_mask = '0; m_cap = '0; m_irq = 1'b0; m_rd = '0; m_prev = '0;
    for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
    cur_in = '0;
    $display("[TB] start");

    // Reset coinciding with a write of 0xFF to DATA: write must be dropped.
    applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 32'hFF, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 8'h00);
    checkOutput("rst_out_port", 32'(out_port), 32'(RSTV));
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_readdata", bus.readdata, 32'd0);

    // Reset state reads.
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 32'd0, 8'h00);
    checkOutput("rd_data_rst", bus.readdata, 32'(RSTV));
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 32'd0, 8'h00);
    checkOutput("rd_edgecap_rst", bus.readdata, 32'd0);

    // Load, set and clear of the output register.
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'hFFFF_FF5A, 8'h00);
    checkOutput("data_5a", 32'(out_port), 32'h5A);
    applyStimulus(1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 32'h81, 8'h00);
    checkOutput("set_db", 32'(out_port), 32'hDB);
    applyStimulus(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 32'h18, 8'h00);
    checkOutput("clr_c3", 32'(out_port), 32'hC3);
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 32'd0, 8'h00);
    checkOutput("rd_c3", bus.readdata, 32'hC3);
    applyStimulus(1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 32'd0, 8'h00);
    checkOutput("rd_outset_zero", bus.readdata, 32'd0);

    // Read and write in the same cycle: read returns pre-write value.
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 32'h3C, 8'h00);
    checkOutput("rw_pre_value", bus.readdata, 32'hC3);
    checkOutput("rw_new_out", 32'(out_port), 32'h3C);

    // Synchroniser latency on INPUT.
    for (int k = 1; k <= SYNC + 3; k++) begin
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 32'd0, 8'h24);
      checkOutput("input_latency", bus.readdata, (k >= SYNC + 1) ? 32'h24 : 32'd0);
    end

`ifdef PLLCFG_PIO_EDGE_IRQ_EN
    // Clear inputs and any captured edges, then arm bit 2.
    idle(SYNC + 2);
    applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 32'd0, 8'h00);
    idle(SYNC + 2);
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 32'hFF, 8'h00);
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 32'h04, 8'h00);
    idle(2);
    checkOutput("irq_idle", 32'(irq), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 8'h04);
    idle(SYNC + 1);
    checkOutput("irq_raise", 32'(irq), 32'd1);
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 32'd0, 8'h04);
    checkOutput("rd_edgecap_04", bus.readdata, 32'h04);
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 32'h04, 8'h04);
    idle(1);
    checkOutput("irq_cleared", 32'(irq), 32'd0);

    // Re-arm bit 2, let it fall, then collide a W1C with a fresh rising edge.
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 8'h00);
    idle(SYNC + 1);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 8'h04);
    idle(SYNC + 2);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 8'h00);
    idle(SYNC + 1);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 8'h04);
    idle(SYNC - 1);
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 32'h04, 8'h04);
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 32'd0, 8'h04);
    checkOutput("collide_edgecap", bus.readdata, 32'h04);
    checkOutput("collide_irq", 32'(irq), 32'd1);
`else
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 32'hFF, 8'h04);
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 32'd0, 8'h00);
    checkOutput("rd_irqmask_off", bus.readdata, 32'd0);
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 32'd0, 8'h04);
    checkOutput("rd_edgecap_off", bus.readdata, 32'd0);
    idle(SYNC + 2);
    checkOutput("irq_off", 32'(irq), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [IN_W-1:0] nin;
      nin = ($urandom_range(0, 3) == 0) ? IN_W'($urandom) : cur_in;
      applyStimulus(($urandom_range(0, 60) == 0), ($urandom_range(0, 5) != 0),
                    3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    $urandom, nin);
    end

    // Reset mid-write again from a non-reset state.
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'hA5, cur_in);
    applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 32'hFF, cur_in);
    checkOutput("rst_mid_write", 32'(out_port), 32'(RSTV));
    checkOutput("rst_mid_read", bus.readdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
